partsel_byte_sequencer: RTL and testbench

- Sequenced byte extractor for a wide register.
- Accepts one DATA_W-bit word plus an extraction program (start bit offset, stride, byte count, bit order) through a load handshake.
- Streams the selected bytes one per accepted transfer on a valid/ready output port.
- Sits between a wide-word producer and byte-serial consumers. It is the controller that sequences the indexed part-select datapath (data[off +: 8], either bit order) that downstream synthesis tests exercise.

---
 rtl/partsel_byte_sequencer.sv | 157 +++++++++++++++
 tb/tb_partsel_byte_sequencer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/partsel_byte_sequencer.sv
// Sequenced byte extractor: loads a wide word plus an extraction program and streams
// the selected bytes (data[off +: 8], either bit order) over a valid/ready port.
module partsel_byte_sequencer #(
    parameter int unsigned DATA_W = 256,
    parameter int unsigned OFF_W  = 8,
    parameter int unsigned CNT_W  = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [DATA_W-1:0] load_data,
    input  logic [OFF_W-1:0]  start_off,
    input  logic [OFF_W-1:0]  stride,
    input  logic [CNT_W-1:0]  count,
    input  logic              msb_first,
    input  logic              abort,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        out_byte,
    output logic              out_last,
    output logic              busy,
    output logic              err_ovf
);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [OFF_W-1:0]  cur_q, cur_d;
    logic [OFF_W-1:0]  stride_q, stride_d;
    logic [CNT_W-1:0]  remaining_q, remaining_d;
    logic              msb_q, msb_d;
    logic [7:0]        out_byte_q, out_byte_d;
    logic              out_valid_q, out_valid_d;
    logic              out_last_q, out_last_d;
    logic              err_ovf_q, err_ovf_d;

    logic              handshake;
    logic [OFF_W-1:0]  next_off;
    logic [8:0]        ext_load, ext_next;

    // Returns {overflow, byte}; bits past DATA_W-1 read as zero.
    function automatic logic [8:0] extract(input logic [DATA_W-1:0] data,
                                           input logic [OFF_W-1:0]  off,
                                           input logic              msb);
        logic [DATA_W+7:0] shifted;
        logic [7:0]        b;
        logic [OFF_W:0]    end_bit;
        shifted = {8'b0, data} >> off;
        for (int i = 0; i < 8; i++) begin
            b[i] = msb ? shifted[7-i] : shifted[i];
        end
        end_bit = {1'b0, off} + (OFF_W+1)'(7);
        return {end_bit > (OFF_W+1)'(DATA_W-1), b};
    endfunction

    assign handshake = out_valid_q & out_ready;
    assign next_off  = cur_q + stride_q;
    assign ext_load  = extract(load_data, start_off, msb_first);
    assign ext_next  = extract(data_q, next_off, msb_q);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (load_valid && count != '0) state_d = StRun;
            StRun:  if (abort || (handshake && out_last_q)) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        data_d      = data_q;
        cur_d       = cur_q;
        stride_d    = stride_q;
        remaining_d = remaining_q;
        msb_d       = msb_q;
        out_byte_d  = out_byte_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        err_ovf_d   = err_ovf_q;
        unique case (state_q)
            StIdle: begin
                if (load_valid) begin
                    data_d      = load_data;
                    cur_d       = start_off;
                    stride_d    = stride;
                    remaining_d = count;
                    msb_d       = msb_first;
                    err_ovf_d   = 1'b0;
                    if (count != '0) begin
                        out_valid_d = 1'b1;
                        out_byte_d  = ext_load[7:0];
                        out_last_d  = (count == CNT_W'(1));
                        err_ovf_d   = ext_load[8];
                    end
                end
            end
            StRun: begin
                // Abort wins over any handshake in the same cycle.
                if (abort || (handshake && out_last_q)) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                end else if (handshake) begin
                    cur_d       = next_off;
                    remaining_d = remaining_q - CNT_W'(1);
                    out_byte_d  = ext_next[7:0];
                    out_last_d  = (remaining_q == CNT_W'(2));
                    err_ovf_d   = err_ovf_q | ext_next[8];
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_q      <= '0;
            cur_q       <= '0;
            stride_q    <= '0;
            remaining_q <= '0;
            msb_q       <= 1'b0;
            out_byte_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            err_ovf_q   <= 1'b0;
        end else begin
            data_q      <= data_d;
            cur_q       <= cur_d;
            stride_q    <= stride_d;
            remaining_q <= remaining_d;
            msb_q       <= msb_d;
            out_byte_q  <= out_byte_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            err_ovf_q   <= err_ovf_d;
        end
    end

    always_comb begin
        load_ready = (state_q == StIdle);
        busy       = (state_q == StRun);
        out_valid  = out_valid_q;
        out_byte   = out_byte_q;
        out_last   = out_last_q;
        err_ovf    = err_ovf_q;
    end

endmodule

// File: tb/tb_partsel_byte_sequencer.sv
// Directed bench for partsel_byte_sequencer: table-driven bursts plus hand-written
// backpressure, abort, count-zero and mid-burst reset sequences.
module tb_partsel_byte_sequencer;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         load_valid;
    logic         load_ready;
    logic [255:0] load_data;
    logic [7:0]   start_off;
    logic [7:0]   stride;
    logic [5:0]   count;
    logic         msb_first;
    logic         abort;
    logic         out_valid;
    logic         out_ready;
    logic [7:0]   out_byte;
    logic         out_last;
    logic         busy;
    logic         err_ovf;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [7:0]  off;
        logic [7:0]  str;
        logic [5:0]  cnt;
        logic        msb;
        logic [31:0] exp_bytes;  // byte k of the burst in bits 8k+7:8k
        logic        exp_ovf;
    } vec_t;

    vec_t vecs [8];

    partsel_byte_sequencer #(
        .DATA_W(256),
        .OFF_W (8),
        .CNT_W (6)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_valid(load_valid),
        .load_ready(load_ready),
        .load_data (load_data),
        .start_off (start_off),
        .stride    (stride),
        .count     (count),
        .msb_first (msb_first),
        .abort     (abort),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_byte  (out_byte),
        .out_last  (out_last),
        .busy      (busy),
        .err_ovf   (err_ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [7:0] off, input logic [7:0] str,
                           input logic [5:0] cnt, input logic msb);
        start_off  = off;
        stride     = str;
        count      = cnt;
        msb_first  = msb;
        load_valid = 1'b1;
        tick();
        load_valid = 1'b0;
    endtask

    initial begin
        for (int k = 0; k < 32; k++) load_data[8*k +: 8] = 8'(k);

        vecs[0] = '{off: 8'd23,  str: 8'd0,  cnt: 6'd1, msb: 1'b0, exp_bytes: 32'h06,       exp_ovf: 1'b0};
        vecs[1] = '{off: 8'd24,  str: 8'd0,  cnt: 6'd1, msb: 1'b1, exp_bytes: 32'hC0,       exp_ovf: 1'b0};
        vecs[2] = '{off: 8'd24,  str: 8'd0,  cnt: 6'd1, msb: 1'b0, exp_bytes: 32'h03,       exp_ovf: 1'b0};
        vecs[3] = '{off: 8'd0,   str: 8'd8,  cnt: 6'd4, msb: 1'b0, exp_bytes: 32'h03020100, exp_ovf: 1'b0};
        vecs[4] = '{off: 8'd252, str: 8'd0,  cnt: 6'd1, msb: 1'b0, exp_bytes: 32'h01,       exp_ovf: 1'b1};
        vecs[5] = '{off: 8'd0,   str: 8'd8,  cnt: 6'd1, msb: 1'b0, exp_bytes: 32'h00,       exp_ovf: 1'b0};
        vecs[6] = '{off: 8'd248, str: 8'd16, cnt: 6'd2, msb: 1'b0, exp_bytes: 32'h011F,     exp_ovf: 1'b0};
        vecs[7] = '{off: 8'd16,  str: 8'd0,  cnt: 6'd3, msb: 1'b1, exp_bytes: 32'h404040,   exp_ovf: 1'b0};

        rst_n      = 1'b0;
        load_valid = 1'b0;
        start_off  = '0;
        stride     = '0;
        count      = '0;
        msb_first  = 1'b0;
        abort      = 1'b0;
        out_ready  = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset out_byte", 32'(out_byte), 32'd0);
        check("reset out_last", 32'(out_last), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset err_ovf", 32'(err_ovf), 32'd0);
        check("reset load_ready", 32'(load_ready), 32'd1);

        out_ready = 1'b1;
        for (int v = 0; v < 8; v++) begin
            check($sformatf("v%0d load_ready pre", v), 32'(load_ready), 32'd1);
            do_load(vecs[v].off, vecs[v].str, vecs[v].cnt, vecs[v].msb);
            for (int k = 0; k < int'(vecs[v].cnt); k++) begin
                check($sformatf("v%0d b%0d valid", v, k), 32'(out_valid), 32'd1);
                check($sformatf("v%0d b%0d byte", v, k), 32'(out_byte),
                      32'(vecs[v].exp_bytes[8*k +: 8]));
                check($sformatf("v%0d b%0d last", v, k), 32'(out_last),
                      32'(k == int'(vecs[v].cnt) - 1));
                if (k == 0) check($sformatf("v%0d err_ovf", v), 32'(err_ovf), 32'(vecs[v].exp_ovf));
                tick();
            end
            check($sformatf("v%0d valid after", v), 32'(out_valid), 32'd0);
            check($sformatf("v%0d load_ready after", v), 32'(load_ready), 32'd1);
        end

        // Backpressure before the second byte; a load attempt in RUN must be ignored.
        do_load(8'd0, 8'd8, 6'd4, 1'b0);
        check("bp b0", 32'(out_byte), 32'h00);
        tick();
        out_ready  = 1'b0;
        load_valid = 1'b1;
        start_off  = 8'd24;
        for (int c = 0; c < 3; c++) begin
            check($sformatf("bp hold%0d valid", c), 32'(out_valid), 32'd1);
            check($sformatf("bp hold%0d byte", c), 32'(out_byte), 32'h01);
            check($sformatf("bp hold%0d ready", c), 32'(load_ready), 32'd0);
            tick();
        end
        load_valid = 1'b0;
        check("bp b1 after stall", 32'(out_byte), 32'h01);
        out_ready = 1'b1;
        tick();
        check("bp b2", 32'(out_byte), 32'h02);
        tick();
        check("bp b3", 32'(out_byte), 32'h03);
        check("bp b3 last", 32'(out_last), 32'd1);
        tick();
        check("bp done", 32'(out_valid), 32'd0);

        // Count zero: nothing emitted, stays idle.
        do_load(8'd0, 8'd8, 6'd0, 1'b0);
        check("cnt0 valid", 32'(out_valid), 32'd0);
        check("cnt0 busy", 32'(busy), 32'd0);
        check("cnt0 load_ready", 32'(load_ready), 32'd1);

        // Abort in IDLE does not block a load.
        abort = 1'b1;
        do_load(8'd24, 8'd0, 6'd1, 1'b0);
        abort = 1'b0;
        check("idle abort valid", 32'(out_valid), 32'd1);
        check("idle abort byte", 32'(out_byte), 32'h03);
        tick();

        // Abort after two of five bytes, with a handshake in the abort cycle.
        do_load(8'd0, 8'd8, 6'd5, 1'b0);
        tick();
        tick();
        check("abort pre byte", 32'(out_byte), 32'h02);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort valid", 32'(out_valid), 32'd0);
        check("abort last", 32'(out_last), 32'd0);
        check("abort busy", 32'(busy), 32'd0);
        check("abort load_ready", 32'(load_ready), 32'd1);
        tick();
        check("abort stays idle", 32'(out_valid), 32'd0);

        // Reset mid-burst with err_ovf set.
        out_ready = 1'b0;
        do_load(8'd252, 8'd8, 6'd3, 1'b0);
        check("rst pre err", 32'(err_ovf), 32'd1);
        check("rst pre busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("rst valid", 32'(out_valid), 32'd0);
        check("rst byte", 32'(out_byte), 32'd0);
        check("rst last", 32'(out_last), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst err", 32'(err_ovf), 32'd0);
        check("rst load_ready", 32'(load_ready), 32'd1);
        out_ready = 1'b1;
        do_load(8'd23, 8'd0, 6'd1, 1'b0);
        check("post rst byte", 32'(out_byte), 32'h06);
        check("post rst last", 32'(out_last), 32'd1);
        tick();
        check("post rst idle", 32'(load_ready), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
